// File: rtl/cdivider_sign.sv
// Sequential sign-magnitude complex divider S = A*conj(B) / |B|^2.
// Two restoring dividers (real, imaginary) share one shifted-divisor register.
module cdivider_sign #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A_real,
  input  logic [DATA_W-1:0] A_img,
  input  logic [DATA_W-1:0] B_real,
  input  logic [DATA_W-1:0] B_img,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] S_real,
  output logic [DATA_W-1:0] S_img,
  output logic              overflow,
  output logic              div_zero
);
  localparam int M  = DATA_W - 1;
  localparam int P  = 2 * M;
  localparam int RW = P + M + 2;
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0]   ar, ai, br, bi;
  logic [CW-1:0]       cnt;
  logic [1:0][RW-1:0]  rem;
  logic [RW-1:0]       dsh;
  logic [1:0][M-1:0]   q;
  logic [1:0]          ovf, neg;
  logic                dz;

  logic [P+1:0] num_re, num_im, abs_re, abs_im;
  logic [P:0]   den;

  function automatic logic [P-1:0] mul(input logic [M-1:0] a, input logic [M-1:0] b);
    return {{M{1'b0}}, a} * {{M{1'b0}}, b};
  endfunction

  function automatic logic [P+1:0] sgn(input logic [P-1:0] m, input logic n);
    logic [P+1:0] e;
    e = {2'b00, m};
    return n ? -e : e;
  endfunction

  // Zero magnitude never carries a sign, so negative zero cannot escape.
  function automatic logic [DATA_W-1:0] fmt(input logic [M-1:0] qq, input logic o,
                                            input logic n, input logic z);
    logic [M-1:0] m;
    m = z ? '0 : (o ? '1 : qq);
    return {n & (|m), m};
  endfunction

  always_comb begin
    num_re = sgn(mul(ar[M-1:0], br[M-1:0]), ar[M] ^ br[M])
           + sgn(mul(ai[M-1:0], bi[M-1:0]), ai[M] ^ bi[M]);
    num_im = sgn(mul(ai[M-1:0], br[M-1:0]), ai[M] ^ br[M])
           - sgn(mul(ar[M-1:0], bi[M-1:0]), ar[M] ^ bi[M]);
    den    = {1'b0, mul(br[M-1:0], br[M-1:0])} + {1'b0, mul(bi[M-1:0], bi[M-1:0])};
    abs_re = num_re[P+1] ? -num_re : num_re;
    abs_im = num_im[P+1] ? -num_im : num_im;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = PREP;
      PREP: state_nx = DIV;
      DIV:  if (cnt == CW'(DATA_W-1)) state_nx = DONE;
      DONE: if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar <= '0; ai <= '0; br <= '0; bi <= '0;
      cnt <= '0; rem <= '0; dsh <= '0; q <= '0;
      ovf <= '0; neg <= '0; dz <= 1'b0;
      out_valid <= 1'b0; S_real <= '0; S_img <= '0;
      overflow <= 1'b0; div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ar <= A_real; ai <= A_img; br <= B_real; bi <= B_img;
        end
        PREP: begin
          rem[0] <= {{(M-FRAC_W){1'b0}}, abs_re, {FRAC_W{1'b0}}};
          rem[1] <= {{(M-FRAC_W){1'b0}}, abs_im, {FRAC_W{1'b0}}};
          dsh    <= {1'b0, den, {M{1'b0}}};
          neg    <= {num_im[P+1], num_re[P+1]};
          dz     <= (den == '0);
          cnt    <= '0;
          q      <= '0;
          ovf    <= '0;
        end
        DIV: begin
          // Step 0 tests the quotient against 2^M; later steps emit one bit each, MSB first.
          cnt <= cnt + CW'(1);
          dsh <= dsh >> 1;
          for (int c = 0; c < 2; c++) begin
            if (cnt == '0) begin
              ovf[c] <= (rem[c] >= dsh);
            end else if (rem[c] >= dsh) begin
              rem[c] <= rem[c] - dsh;
              q[c]   <= {q[c][M-2:0], 1'b1};
            end else begin
              q[c]   <= {q[c][M-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            S_real    <= fmt(q[0], ovf[0], neg[0], dz);
            S_img     <= fmt(q[1], ovf[1], neg[1], dz);
            overflow  <= ~dz & (|ovf);
            div_zero  <= dz;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
